// File: rtl/write_data_buffer.sv
// Write data buffer: stores host beats in a circular FIFO, pads short transfers
// to full bursts and drains one burst at a time to the DRAM PHY after WR_LAT cycles.
module write_data_buffer #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int DEPTH     = 16,
    parameter int WR_LAT    = 4
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic [DATA_W/8-1:0]                  in_strb,
    input  logic                                 in_last,
    output logic                                 burst_avail,
    input  logic                                 wr_start,
    output logic                                 busy,
    output logic                                 phy_wr_en,
    output logic [DATA_W-1:0]                    phy_wr_data,
    output logic [DATA_W/8-1:0]                  phy_wr_mask,
    output logic                                 wr_done,
    output logic [$clog2(DEPTH/BURST_LEN):0]     burst_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LAT_W  = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam int BC_W   = $clog2(DEPTH / BURST_LEN) + 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'((WR_LAT > 1) ? (WR_LAT - 2) : 0);
    localparam logic [LAT_W-1:0]  LAT_ZERO  = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [BC_W-1:0]   BC_ZERO   = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]   BC_ONE    = BC_W'(1);

    typedef enum logic [1:0] {IDLE, LAT, STREAM, DONE} state_t;

    logic [DATA_W-1:0] mem_data_r [DEPTH];
    logic [STRB_W-1:0] mem_strb_r [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [BEAT_W-1:0] beat_in_r, beat_out_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [BC_W-1:0]   burst_cnt_r;
    logic              padding_r;
    state_t            state_r, state_nxt_s;
    logic              phy_wr_en_r, wr_done_r;
    logic [DATA_W-1:0] phy_wr_data_r;
    logic [STRB_W-1:0] phy_wr_mask_r;

    logic              full_s, push_host_s, push_pad_s, push_s, pop_s;
    logic              burst_done_s, drain_acc_s;
    logic [DATA_W-1:0] push_data_s;
    logic [STRB_W-1:0] push_strb_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
    endfunction

    assign full_s       = (count_r == CNT_FULL);
    assign in_ready     = !full_s && !padding_r;
    assign push_host_s  = in_valid && in_ready;
    assign push_pad_s   = padding_r && !full_s;
    assign push_s       = push_host_s || push_pad_s;
    assign push_data_s  = padding_r ? {DATA_W{1'b0}} : in_data;
    assign push_strb_s  = padding_r ? {STRB_W{1'b0}} : in_strb;
    assign burst_done_s = push_s && (beat_in_r == BEAT_LAST);
    assign pop_s        = (state_r == STREAM);
    assign drain_acc_s  = (state_r == IDLE) && wr_start && burst_avail;

    assign burst_avail  = (burst_cnt_r != BC_ZERO);
    assign burst_cnt    = burst_cnt_r;
    assign busy         = (state_r != IDLE);
    assign phy_wr_en    = phy_wr_en_r;
    assign phy_wr_data  = phy_wr_data_r;
    assign phy_wr_mask  = phy_wr_mask_r;
    assign wr_done      = wr_done_r;

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= push_data_s;
            mem_strb_r[wr_ptr_r] <= push_strb_s;
        end
    end

    // Pointers, occupancy, beat-in-burst counter, padding and burst accounting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= {CNT_W{1'b0}};
            beat_in_r   <= BEAT_ZERO;
            padding_r   <= 1'b0;
            burst_cnt_r <= BC_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r  <= ptr_inc(wr_ptr_r);
                beat_in_r <= (beat_in_r == BEAT_LAST) ? BEAT_ZERO : beat_in_r + BEAT_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // A short transfer pads until the burst's last slot is written.
            if (push_host_s && in_last && (beat_in_r != BEAT_LAST)) begin
                padding_r <= 1'b1;
            end else if (push_pad_s && (beat_in_r == BEAT_LAST)) begin
                padding_r <= 1'b0;
            end
            case ({burst_done_s, drain_acc_s})
                2'b10:   burst_cnt_r <= burst_cnt_r + BC_ONE;
                2'b01:   burst_cnt_r <= burst_cnt_r - BC_ONE;
                default: burst_cnt_r <= burst_cnt_r;
            endcase
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (drain_acc_s) begin
                    state_nxt_s = (WR_LAT == 1) ? STREAM : LAT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAT: begin
                if (lat_cnt_r == LAT_ZERO) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = LAT;
                end
            end
            STREAM: begin
                if (beat_out_r == BEAT_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Drain FSM state, latency/beat counters and registered PHY outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= IDLE;
            lat_cnt_r     <= LAT_ZERO;
            beat_out_r    <= BEAT_ZERO;
            phy_wr_en_r   <= 1'b0;
            phy_wr_data_r <= {DATA_W{1'b0}};
            phy_wr_mask_r <= {STRB_W{1'b0}};
            wr_done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lat_cnt_r  <= (state_r == LAT) ? lat_cnt_r - LAT_ONE : LAT_INIT;
            beat_out_r <= (state_r == STREAM) ? beat_out_r + BEAT_ONE : BEAT_ZERO;
            phy_wr_en_r   <= pop_s;
            phy_wr_data_r <= pop_s ? mem_data_r[rd_ptr_r] : {DATA_W{1'b0}};
            phy_wr_mask_r <= pop_s ? ~mem_strb_r[rd_ptr_r] : {STRB_W{1'b0}};
            wr_done_r     <= (state_r == DONE);
        end
    end

endmodule

// File: tb/tb_write_data_buffer.sv
// Bench for write_data_buffer: table-driven directed cycles, hand corner sequences
// and random traffic, all checked against a queue-based reference model.
module tb_write_data_buffer;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int DP = 8;
    localparam int WL = 3;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_strb = 4'h0;
    logic        in_last = 1'b0;
    logic        burst_avail;
    logic        wr_start = 1'b0;
    logic        busy;
    logic        phy_wr_en;
    logic [31:0] phy_wr_data;
    logic [3:0]  phy_wr_mask;
    logic        wr_done;
    logic [1:0]  burst_cnt;

    always #5 clk = ~clk;

    write_data_buffer #(.DATA_W(DW), .BURST_LEN(BL), .DEPTH(DP), .WR_LAT(WL)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_strb(in_strb), .in_last(in_last),
        .burst_avail(burst_avail), .wr_start(wr_start), .busy(busy),
        .phy_wr_en(phy_wr_en), .phy_wr_data(phy_wr_data), .phy_wr_mask(phy_wr_mask),
        .wr_done(wr_done), .burst_cnt(burst_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: FIFO contents as a queue, plus transfer bookkeeping.
    int          e = 0;
    int          occ, pos, bursts, drain_edge;
    bit          padding, drain_act;
    logic [35:0] fifo_q[$];

    typedef struct {
        bit v; logic [31:0] d; logic [3:0] s; bit l; bit ws;
        bit r; logic [1:0] c; bit b; bit en; logic [31:0] pd; logic [3:0] pm; bit xd;
    } vec_t;
    vec_t tbl[25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        occ = 0; pos = 0; bursts = 0; drain_edge = 0;
        padding = 1'b0; drain_act = 1'b0;
        fifo_q.delete();
    endtask

    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] s,
                        input bit l, input bit ws);
        int ne;
        bit m_ready, pop, acc, push_h, push_p, comp, x_en, x_busy, x_done;
        logic [35:0] ent;
        logic [31:0] x_data;
        logic [3:0]  x_mask;
        in_valid = v; in_data = d; in_strb = s; in_last = l; wr_start = ws;
        ne      = e + 1;
        m_ready = !padding && (occ < DP);
        pop     = drain_act && (ne >= drain_edge + WL) && (ne <= drain_edge + WL + BL - 1);
        acc     = ws && (!drain_act || ne >= drain_edge + WL + BL + 1) && (bursts > 0);
        push_h  = v && m_ready;
        push_p  = padding;
        comp    = 1'b0;
        if (push_h || push_p) begin
            fifo_q.push_back(push_h ? {d, s} : 36'h0);
            comp = (pos == BL - 1);
            pos  = (pos + 1) % BL;
            if (push_h && l && !comp) padding = 1'b1;
            if (push_p && comp) padding = 1'b0;
            occ++;
        end
        x_en = 1'b0; x_data = 32'h0; x_mask = 4'h0;
        if (pop) begin
            ent = fifo_q.pop_front();
            x_en = 1'b1; x_data = ent[35:4]; x_mask = ~ent[3:0];
            occ--;
        end
        if (comp) bursts++;
        if (acc) begin bursts--; drain_act = 1'b1; drain_edge = ne; end
        @(posedge clk);
        e = ne;
        @(negedge clk);
        x_busy = drain_act && (e <= drain_edge + WL + BL - 1);
        x_done = drain_act && (e == drain_edge + WL + BL);
        chk("in_ready", in_ready, !padding && (occ < DP));
        chk("burst_cnt", burst_cnt, bursts);
        chk("burst_avail", burst_avail, bursts > 0);
        chk("busy", busy, x_busy);
        chk("phy_wr_en", phy_wr_en, x_en);
        chk("phy_wr_data", phy_wr_data, x_data);
        chk("phy_wr_mask", phy_wr_mask, x_mask);
        chk("wr_done", wr_done, x_done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_burst_avail"}, burst_avail, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_phy_wr_en"}, phy_wr_en, 1'b0);
        chk({tag, "_phy_wr_data"}, phy_wr_data, 32'h0);
        chk({tag, "_phy_wr_mask"}, phy_wr_mask, 4'h0);
        chk({tag, "_wr_done"}, wr_done, 1'b0);
        chk({tag, "_burst_cnt"}, burst_cnt, 2'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; wr_start = 1'b0; in_last = 1'b0;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        n_rst = 1'b1;
        e += 2;
        model_reset();
        chk("rst_release_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        // v, d, s, l, ws | ready, cnt, busy, en, data, mask, done
        tbl[0]  = '{1'b1, 32'hA0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'hA1, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[2]  = '{1'b1, 32'hA2, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'hA3, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hA0, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hA1, 4'h0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hA2, 4'h0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hA3, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1};
        tbl[12] = '{1'b1, 32'hB0, 4'h3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[13] = '{1'b1, 32'hB1, 4'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[15] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[16] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[17] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[18] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0,  4'h0, 1'b0};
        tbl[19] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hB0, 4'hC, 1'b0};
        tbl[20] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'hB1, 4'hC, 1'b0};
        tbl[21] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h0,  4'hF, 1'b0};
        tbl[22] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 32'h0,  4'hF, 1'b0};
        tbl[23] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b1};
        tbl[24] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  4'h0, 1'b0};

        model_reset();
        #1;
        do_reset();

        // Directed table: full burst drain, then short transfer with padding.
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].l, tbl[i].ws);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].r);
            chk($sformatf("tbl%0d_cnt", i), burst_cnt, tbl[i].c);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("tbl%0d_en", i), phy_wr_en, tbl[i].en);
            chk($sformatf("tbl%0d_data", i), phy_wr_data, tbl[i].pd);
            chk($sformatf("tbl%0d_mask", i), phy_wr_mask, tbl[i].pm);
            chk($sformatf("tbl%0d_done", i), wr_done, tbl[i].xd);
        end

        // Fill to capacity, then a single drain frees space only after the first pop.
        for (int i = 0; i < 8; i++) step(1'b1, 32'hC0 + i, 4'hF, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_burst_cnt", burst_cnt, 2'd2);
        step(1'b1, 32'hC8, 4'hF, 1'b0, 1'b1);
        chk("full_ready_n0", in_ready, 1'b0);
        step(1'b1, 32'hC8, 4'hF, 1'b0, 1'b0);
        chk("full_ready_n1", in_ready, 1'b0);
        step(1'b1, 32'hC8, 4'hF, 1'b0, 1'b0);
        chk("full_ready_n2", in_ready, 1'b0);
        step(1'b1, 32'hC8, 4'hF, 1'b0, 1'b0);
        chk("full_ready_after_pop", in_ready, 1'b1);
        step(1'b1, 32'hC8, 4'hF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("start_in_stream_busy", busy, 1'b1);
        chk("start_in_stream_cnt", burst_cnt, 2'd1);
        idle(5);
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(9);
        // Only the partial burst holding the ninth beat remains; it must not drain.
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("partial_no_drain_busy", busy, 1'b0);
        chk("partial_no_avail", burst_avail, 1'b0);
        step(1'b1, 32'hC9, 4'h5, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(9);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a stream aborts it with no wr_done.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + i, 4'hF, i == 3, 1'b0);
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        idle(4);
        chk("pre_abort_en", phy_wr_en, 1'b1);
        #1 n_rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        e += 2;
        model_reset();
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_data_buffer.md
WRITE_DATA_BUFFER -- requirements
Module: write_data_buffer

Interface
REQ-001 Parameter DATA_W, default 32: data beat width in bits; multiple of 8.
REQ-002 Parameter BURST_LEN, default 8: beats per DRAM write burst; power of 2.
REQ-003 Parameter DEPTH, default 16: buffer entries; integer multiple of BURST_LEN, at least 2*BURST_LEN.
REQ-004 Parameter WR_LAT, default 4: write latency in cycles from accepted wr_start to first PHY beat; at least 1.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  host beat valid.
REQ-008 in_ready  out  1  buffer accepts beat this cycle.
REQ-009 in_data  in  DATA_W  host write data.
REQ-010 in_strb  in  DATA_W/8  byte enables; 1 = byte written.
REQ-011 in_last  in  1  final beat of host transfer.
REQ-012 burst_avail  out  1  at least one complete burst is stored.
REQ-013 wr_start  in  1  scheduler request to drain one burst to the PHY.
REQ-014 busy  out  1  drain in progress (any state other than IDLE).
REQ-015 phy_wr_en  out  1  PHY write beat valid.
REQ-016 phy_wr_data  out  DATA_W  PHY write data.
REQ-017 phy_wr_mask  out  DATA_W/8  DDR data mask; 1 = byte masked, equal to inverted strobe.
REQ-018 wr_done  out  1  one-cycle pulse after the last beat of a burst.
REQ-019 burst_cnt  out  $clog2(DEPTH/BURST_LEN)+1  number of complete bursts stored.

Function
REQ-020 Storage is a circular FIFO of DEPTH entries of {data, strb}; write and read pointers wrap from DEPTH-1 to 0.
REQ-021 Beat accepted iff in_valid && in_ready at a rising edge.
REQ-022 in_ready = !full && !padding; full means DEPTH entries occupied.
REQ-023 Beat-in-burst counter counts accepted beats modulo BURST_LEN; reaching BURST_LEN completes a burst and increments burst_cnt.
REQ-024 in_last on beat index BURST_LEN-1 completes the burst normally.
REQ-025 in_last on beat index k < BURST_LEN-1 enters padding: one pad entry per cycle (data 0, strb 0) for BURST_LEN-1-k cycles, in_ready low meanwhile; burst completes on the final pad write.
REQ-026 in_last absent at beat index BURST_LEN-1 still completes the burst; the next beat starts a new burst (long transfers split into bursts).
REQ-027 Drain FSM states: IDLE, LAT, STREAM, DONE.
REQ-028 IDLE -> LAT when wr_start && burst_avail; burst_cnt decrements on that edge; wr_start without burst_avail, or outside IDLE, is ignored.
REQ-029 LAT counts down WR_LAT-1 cycles, then goes to STREAM; WR_LAT=1 goes straight from IDLE to STREAM.
REQ-030 With wr_start accepted at edge N, phy_wr_en is high for cycles N+WR_LAT through N+WR_LAT+BURST_LEN-1 exactly, one FIFO entry per cycle in order.
REQ-031 phy_wr_data and phy_wr_mask are registered, valid while phy_wr_en is high, and 0 otherwise.
REQ-032 STREAM -> DONE after the BURST_LEN-th beat; wr_done is high for the single DONE cycle; DONE -> IDLE always.
REQ-033 Simultaneous push and pop in one cycle leaves occupancy unchanged; entries freed by the pop are not reusable until the next cycle.
REQ-034 Burst completion and drain acceptance on the same edge leave burst_cnt unchanged.
REQ-035 A partially filled burst never raises burst_avail and is never drained.
REQ-036 Full FIFO with in_valid high holds in_ready low; no beat is lost or overwritten.

Reset
REQ-037 n_rst low asynchronously clears pointers, occupancy, beat counter, padding flag, burst_cnt, and FSM (to IDLE).
REQ-038 Output values while n_rst is low: in_ready=1, burst_avail=0, busy=0, phy_wr_en=0, phy_wr_data=0, phy_wr_mask=0, wr_done=0, burst_cnt=0.
REQ-039 Reset mid-drain aborts the burst immediately; all stored data is discarded.

Verification (DATA_W=32, BURST_LEN=4, DEPTH=8, WR_LAT=3)
REQ-040 Reset held 2 cycles -> outputs per REQ-038; in_ready=1 on first cycle after release.
REQ-041 Push 4 beats 0xA0..0xA3, strb 0xF, in_last on 4th -> burst_cnt=1; wr_start at edge N -> phy_wr_en on N+3..N+6 with data A0..A3, mask 0x0; wr_done on N+7.
REQ-042 Push 2 beats 0xB0,0xB1 (strb 0x3, in_last on 2nd) -> in_ready low 2 cycles; drained burst is B0,B1,0,0 with masks 0xC,0xC,0xF,0xF.
REQ-043 Push 9 beats with no drain -> 8 accepted, in_ready=0, burst_cnt=2; one wr_start -> in_ready=1 only after the first pop; the 9th beat is stored as burst 3, beat 0.
REQ-044 wr_start with burst_cnt=0, and wr_start during STREAM -> ignored; busy and phy_wr_en unchanged.
REQ-045 n_rst pulsed low during STREAM beat 2 -> phy_wr_en=0 immediately; burst_cnt=0; no wr_done.
